// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StFault
  } state_e;

  // ALU command encodings (Instr[24:21] for data-processing).
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0010;
  localparam logic [3:0] AluAdd = 4'b0100;
  localparam logic [3:0] AluCmp = 4'b1010;
  localparam logic [3:0] AluOrr = 4'b1100;

  // Instruction class, Instr[27:26].
  localparam logic [1:0] OpDp     = 2'b00;
  localparam logic [1:0] OpMem    = 2'b01;
  localparam logic [1:0] OpBranch = 2'b10;
  localparam logic [1:0] OpNop    = 2'b11;

  // Condition field, Instr[31:28].
  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

  // Only arithmetic commands produce meaningful carry/overflow.
  function automatic logic alu_sets_cv(input logic [3:0] cmd);
    logic res;
    res = 1'b0;
    case (cmd)
      AluAdd, AluSub, AluCmp: res = 1'b1;
      AluAnd, AluOrr:         res = 1'b0;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// Condition evaluation and NZCV next-value computation (combinational).
module cond_unit
  import ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,      // stored NZCV
  input  logic [3:0] alu_flags_i,  // NZCV from ALU this cycle
  input  logic       s_i,
  input  logic [3:0] cmd_i,
  output logic       pass_o,
  output logic       nz_we_o,
  output logic       cv_we_o,
  output logic [3:0] flags_next_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  // Standard ARM condition table; 1111 is treated as never.
  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      CondEq: pass_o = z;
      CondNe: pass_o = ~z;
      CondCs: pass_o = c;
      CondCc: pass_o = ~c;
      CondMi: pass_o = n;
      CondPl: pass_o = ~n;
      CondVs: pass_o = v;
      CondVc: pass_o = ~v;
      CondHi: pass_o = c & ~z;
      CondLs: pass_o = ~c | z;
      CondGe: pass_o = (n == v);
      CondLt: pass_o = (n != v);
      CondGt: pass_o = ~z & (n == v);
      CondLe: pass_o = z | (n != v);
      CondAl: pass_o = 1'b1;
      CondNv: pass_o = 1'b0;
    endcase
  end

  assign nz_we_o = s_i;
  assign cv_we_o = s_i & alu_sets_cv(cmd_i);

  // Merge new flag fields with the held ones according to the write enables.
  always_comb begin
    flags_next_o[3:2] = nz_we_o ? alu_flags_i[3:2] : flags_i[3:2];
    flags_next_o[1:0] = cv_we_o ? alu_flags_i[1:0] : flags_i[1:0];
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM controller: FSM, NZCV register and memory-wait watchdog.
// Optional feature: define CTRL_BYTE_EN to drive byte-lane enables for LDRB/STRB.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 4,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic [1:0]           AdrLow,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           be,
  output logic                 bus_fault
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic [3:0] cond, cmd, flags_next, alu_cmd;
  logic [1:0] op;
  logic       cond_pass, bit_i, bit_s, bit_u, bit_l;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign bit_i = Instr[25];
  assign cmd   = Instr[24:21];
  assign bit_u = Instr[23];
  assign bit_s = Instr[20];
  assign bit_l = Instr[20];

`ifdef CTRL_BYTE_EN
  logic unused_instr;
  assign unused_instr = ^Instr[19:0];
`else
  logic unused_instr;
  assign unused_instr = ^{Instr[19:0], AdrLow};
`endif

  cond_unit u_cond (
    .cond_i       (cond),
    .flags_i      (flags_q),
    .alu_flags_i  (ALUFlags),
    .s_i          (bit_s),
    .cmd_i        (cmd),
    .pass_o       (cond_pass),
    .nz_we_o      (),
    .cv_we_o      (),
    .flags_next_o (flags_next)
  );

  // State, flags and watchdog registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StFetch;
      flags_q    <= 4'b0000;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Flags commit only on the edge that ends ALUWB.
  always_comb begin
    flags_d = (state_q == StAluWb) ? flags_next : flags_q;
  end

  // Next-state, datapath strobes, watchdog and reset gating of all outputs.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 8'd0;
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 2'b00;
    alu_cmd    = AluAnd;

    unique case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        alu_cmd   = AluAdd;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!cond_pass) begin
          state_d = StFetch;
        end else begin
          case (op)
            OpDp:     state_d = bit_i ? StExecI : StExecR;
            OpMem:    state_d = StMemAdr;
            OpBranch: state_d = StBranch;
            OpNop:    state_d = StFetch;
          endcase
        end
      end
      StExecR, StExecI: begin
        alu_cmd = cmd;
        ALUSrcB = (state_q == StExecI) ? 2'b01 : 2'b00;
        state_d = StAluWb;
      end
      StAluWb: begin
        // ALU inputs held so ALUFlags stay valid for the flag update.
        alu_cmd   = cmd;
        ALUSrcB   = bit_i ? 2'b01 : 2'b00;
        RegWrite  = (cmd != AluCmp);
        ResultSrc = 2'b00;
        state_d   = StFetch;
      end
      StMemAdr: begin
        alu_cmd = bit_u ? AluAdd : AluSub;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
        state_d = bit_l ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWrite: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = mem_ready;
        if (mem_ready) state_d = StFetch;
      end
      StMemWb: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b01;
        state_d   = StFetch;
      end
      StBranch: begin
        ImmSrc    = 2'b10;
        ALUSrcB   = 2'b01;
        alu_cmd   = AluAdd;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        state_d   = StFetch;
      end
      StFault: state_d = StFault;
      default: state_d = StFetch;
    endcase

    // Count consecutive stalled requests; reaching the limit parks in FAULT.
    if (mem_req && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
      if (wait_cnt_d == MaxWait) state_d = StFault;
    end

    RegSrc     = {(op == OpMem) & ~bit_l, (op == OpBranch)};
    ALUControl = ALUCTRL_W'(alu_cmd);
    be         = 4'hF;
`ifdef CTRL_BYTE_EN
    if (Instr[22] && (state_q inside {StMemRead, StMemWrite, StMemWb})) begin
      be = 4'b0001 << AdrLow;
    end
`endif

    if (!reset) begin
      mem_req    = 1'b0;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ImmSrc     = 2'b00;
      RegSrc     = 2'b00;
      ALUControl = '0;
      be         = 4'h0;
    end
  end

  assign bus_fault = (state_q == StFault);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; honours CTRL_BYTE_EN for byte-lane expectations.
module tb_multicycle_ctrl;

  localparam logic [31:0] InsAdd  = 32'hE082_1003;  // ADD R1,R2,R3
  localparam logic [31:0] InsCmp  = 32'hE152_0003;  // CMP R2,R3
  localparam logic [31:0] InsBeq  = 32'h0A00_0002;  // BEQ
  localparam logic [31:0] InsLdr  = 32'hE592_1004;  // LDR R1,[R2,#4]
  localparam logic [31:0] InsStrb = 32'hE542_1000;  // STRB R1,[R2,#-0]

`ifdef CTRL_BYTE_EN
  localparam logic [3:0] BeStrb = 4'b0100;
`else
  localparam logic [3:0] BeStrb = 4'hF;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  AdrLow;
  logic        mem_ready;
  logic        mem_req, PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [3:0]  ALUControl, be;
  logic        bus_fault;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  multicycle_ctrl #(
    .ALUCTRL_W (4),
    .MAX_WAIT  (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .AdrLow     (AdrLow),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .be         (be),
    .bus_fault  (bus_fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, apply inputs just after the edge, sample at the falling edge.
  task automatic step(input logic [31:0] ins, input logic rdy);
    @(posedge clk);
    #1;
    Instr     = ins;
    mem_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b0;
    Instr     = 32'h0;
    ALUFlags  = 4'b0100;
    AdrLow    = 2'b00;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_be", 32'(be), 32'd0);
    check_eq("rst_aluctl", 32'(ALUControl), 32'd0);
    check_eq("rst_srcb", 32'(ALUSrcB), 32'd0);
    check_eq("rst_fault", 32'(bus_fault), 32'd0);

    // ADD, zero wait states: FETCH DECODE EXECR ALUWB.
    @(posedge clk);
    #1;
    reset = 1'b1;
    Instr = InsAdd;
    @(negedge clk);
    check_eq("add_f_req", 32'(mem_req), 32'd1);
    check_eq("add_f_ir", 32'(IRWrite), 32'd1);
    check_eq("add_f_pc", 32'(PCWrite), 32'd1);
    check_eq("add_f_sel", 32'({ALUSrcA, ALUSrcB, ResultSrc, ALUControl}), 32'b1_10_10_0100);
    check_eq("add_f_be", 32'(be), 32'hF);
    step(InsAdd, 1'b1);
    check_eq("add_d_req", 32'(mem_req), 32'd0);
    step(InsAdd, 1'b1);
    check_eq("add_x_alu", 32'({ALUControl, ALUSrcB, RegWrite}), 32'b0100_00_0);
    step(InsAdd, 1'b1);
    check_eq("add_wb_rw", 32'({RegWrite, ResultSrc}), 32'b1_00);

    // BEQ with Z still clear (ADD had S=0): DECODE returns to FETCH.
    step(InsBeq, 1'b1);
    check_eq("beq0_f_req", 32'(mem_req), 32'd1);
    step(InsBeq, 1'b1);
    check_eq("beq0_d_pc", 32'(PCWrite), 32'd0);
    step(InsBeq, 1'b1);
    check_eq("beq0_fetch", 32'({mem_req, PCWrite}), 32'b11);

    // CMP sets Z from ALUFlags, no register write.
    step(InsCmp, 1'b1);
    step(InsCmp, 1'b1);
    check_eq("cmp_x_alu", 32'(ALUControl), 32'hA);
    step(InsCmp, 1'b1);
    check_eq("cmp_wb_rw", 32'(RegWrite), 32'd0);

    // BEQ now taken.
    step(InsBeq, 1'b1);
    check_eq("beq1_f_req", 32'(mem_req), 32'd1);
    step(InsBeq, 1'b1);
    step(InsBeq, 1'b1);
    check_eq("beq1_br", 32'({mem_req, PCWrite, ImmSrc, RegSrc, ALUControl}), 32'b0_1_10_01_0100);

    // LDR with three stalled MEMREAD cycles.
    step(InsLdr, 1'b1);
    check_eq("ldr_f_req", 32'(mem_req), 32'd1);
    step(InsLdr, 1'b1);
    step(InsLdr, 1'b1);
    check_eq("ldr_ma", 32'({mem_req, ALUControl, ImmSrc, RegSrc}), 32'b0_0100_01_00);
    for (int i = 0; i < 3; i++) begin
      step(InsLdr, 1'b0);
      check_eq("ldr_rd_wait", 32'({mem_req, AdrSrc, RegWrite}), 32'b110);
    end
    step(InsLdr, 1'b1);
    check_eq("ldr_rd_rdy", 32'({mem_req, AdrSrc}), 32'b11);
    step(InsLdr, 1'b1);
    check_eq("ldr_wb", 32'({mem_req, RegWrite, ResultSrc, be}), 32'b0_1_01_1111);

    // STRB, U=0, one wait cycle in MEMWRITE.
    AdrLow = 2'b10;
    step(InsStrb, 1'b1);
    step(InsStrb, 1'b1);
    step(InsStrb, 1'b1);
    check_eq("strb_ma", 32'({ALUControl, RegSrc}), 32'b0010_10);
    step(InsStrb, 1'b0);
    check_eq("strb_wr_wait", 32'({mem_req, MemWrite}), 32'b10);
    check_eq("strb_be_wait", 32'(be), 32'(BeStrb));
    step(InsStrb, 1'b1);
    check_eq("strb_wr_rdy", 32'({mem_req, MemWrite}), 32'b11);
    check_eq("strb_be_rdy", 32'(be), 32'(BeStrb));
    step(InsLdr, 1'b1);
    check_eq("strb_done", 32'({mem_req, MemWrite}), 32'b10);

    // Reset asserted during MEMADR.
    step(InsLdr, 1'b1);
    step(InsLdr, 1'b1);
    check_eq("rma_pre", 32'(ImmSrc), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rma_async", 32'({mem_req, ALUControl, ImmSrc, be}), 32'd0);
    @(negedge clk);
    check_eq("rma_wr0", 32'({RegWrite, MemWrite}), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rma_wr1", 32'({RegWrite, MemWrite}), 32'd0);

    // Release into a FETCH that never completes: watchdog fires after 15 cycles.
    @(posedge clk);
    #1;
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("wd_first", 32'({mem_req, IRWrite, bus_fault}), 32'b100);
    for (int i = 0; i < 14; i++) begin
      step(InsLdr, 1'b0);
      check_eq("wd_stall", 32'({mem_req, bus_fault}), 32'b10);
    end
    step(InsLdr, 1'b1);
    check_eq("wd_fault", 32'({bus_fault, mem_req, PCWrite, IRWrite}), 32'b1000);
    step(InsLdr, 1'b1);
    check_eq("wd_sticky", 32'({bus_fault, mem_req}), 32'b10);

    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("wd_rst", 32'(bus_fault), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("wd_recover", 32'({mem_req, bus_fault}), 32'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle successor to the single-cycle ARM controller. It is a state machine that sequences each instruction over 3–5 cycles around one shared memory port, with a ready handshake and a bus-wait watchdog. It holds the NZCV flag register and evaluates condition codes internally, so the datapath receives only gated write strobes. It sits between the instruction register/ALU and the shared memory and register file.

## Interface
- ALUCTRL_W, 4, width of ALUControl
- MAX_WAIT, 15, consecutive stalled memory cycles before fault (1..255)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = in reset)
- Instr  in  32  instruction register contents
- ALUFlags  in  4  NZCV from ALU, current cycle
- AdrLow  in  2  byte address bits of current data address
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access requested
- PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite  out  1 each  datapath strobes
- ALUSrcA  out  1; ALUSrcB  out  2; ResultSrc  out  2; ImmSrc  out  2; RegSrc  out  2
- ALUControl  out  ALUCTRL_W  ALU operation
- be  out  4  byte-lane enables
- bus_fault  out  1  sticky watchdog fault

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, FAULT.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=2'b10, ALUControl=ADD (4'b0100), ResultSrc=2'b10.
  - On mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Otherwise hold.
- DECODE:
  - Evaluate Instr[31:28] against the stored flags (standard ARM EQ..AL; 4'b1111 is treated as never).
  - Condition fails: return to FETCH with no writes.
  - Condition passes, op=Instr[27:26]:
    - 00 goes to EXECI if Instr[25], otherwise EXECR.
    - 01 goes to MEMADR.
    - 10 goes to BRANCH.
    - 11 goes to FETCH (no-op).
- EXECR/EXECI:
  - ALUControl=Instr[24:21].
  - ALUSrcB is 2'b00 (register) or 2'b01 (immediate); ImmSrc=2'b00.
  - Next state ALUWB.
- ALUWB:
  - RegWrite=1 unless cmd=CMP (4'b1010), ResultSrc=2'b00.
  - If S=Instr[20]: NZ ← ALUFlags[3:2].
  - If S and cmd ∈ {ADD, SUB, CMP}: CV ← ALUFlags[1:0].
  - Next state FETCH.
- MEMADR: ALUControl=ADD (or SUB if U=Instr[23]=0), ImmSrc=2'b01. Go to MEMREAD if L=Instr[20], otherwise MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. On mem_ready go to MEMWB.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=mem_ready. On mem_ready go to FETCH.
- MEMWB: RegWrite=1, ResultSrc=2'b01, then FETCH.
- BRANCH: ImmSrc=2'b10, ALUControl=ADD, PCWrite=1, then FETCH.
- RegSrc: bit0 = (op==10), bit1 = (op==01 and !L).
- Watchdog:
  - 8-bit counter increments while mem_req=1 and mem_ready=0, and clears on mem_ready or when not requesting.
  - When the count reaches MAX_WAIT, go to FAULT.
  - In FAULT, bus_fault=1 and all strobes and mem_req are 0. FAULT is left only by reset.

## Timing
- Latency, with zero wait states:
  - Data-processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Failed condition: 2 cycles.
- Each cycle mem_ready is low in FETCH/MEMREAD/MEMWRITE adds one cycle.
- Flags update on the clock edge that ends ALUWB. A following instruction sees the new flags in its DECODE.
- Reset values: state=FETCH, Flags=4'b0000, counter=0, bus_fault=0.
- Outputs during reset: all strobes and mem_req are 0, and ALUControl, be and every select output are 0.
  - The first FETCH request happens in the first cycle after reset goes high.
- Reset mid-instruction: state aborts immediately to FETCH, with no partial write.
- mem_ready is ignored in states that do not request memory.

## Configuration
- CTRL_BYTE_EN defined:
  - For an LDRB/STRB access (B=Instr[22]=1) in MEMREAD/MEMWRITE/MEMWB, be = 4'b0001 << AdrLow.
  - Otherwise be = 4'hF.
- CTRL_BYTE_EN undefined: be = 4'hF whenever reset is high. The B bit is ignored.

## Structure
- Package ctrl_pkg holds:
  - the state enum;
  - the ALU command constants ADD/SUB/AND/ORR/CMP;
  - the op and cond encodings.
- Sub-module cond_unit (combinational) evaluates cond against the flags and produces pass, flag write enables and the next NZCV. The FSM, flag register and watchdog live in multicycle_ctrl.

## Test plan
- ADD R1,R2,R3 (0xE0821003), mem_ready=1: states are FETCH→DECODE→EXECR→ALUWB. RegWrite=1 in cycle 4 and Flags are unchanged.
- CMP (0xE1520003) with ALUFlags=4'b0100, then BEQ (0x0A000002): Flags become 4'b0100 and the branch reaches BRANCH with PCWrite=1. With Z=0, BEQ returns to FETCH after DECODE.
- LDR with mem_ready low for 3 cycles in MEMREAD: MEMREAD is held for 4 cycles and RegWrite=1 in MEMWB.
- STRB, CTRL_BYTE_EN defined, AdrLow=2'b10: be=4'b0100 and MemWrite is high only in the ready cycle. With the macro undefined, be=4'hF.
- mem_ready stuck low in FETCH: FAULT is entered after 15 cycles with bus_fault=1. Dropping reset low, then releasing it, returns to FETCH with bus_fault=0.
- Reset asserted during MEMADR: outputs go to 0 asynchronously and no RegWrite/MemWrite occurs.
